// File: rtl/fp_pkg.sv
// Shared widths and the item record carried through the normalizer pipeline.
package fp_pkg;

  localparam int MANT_W = 24;
  localparam int EXP_W  = 8;
  localparam int IDX_W  = $clog2(32);
  localparam int LO_W   = 3;

  typedef struct packed {
    logic [MANT_W-1:0] mant;
    logic [EXP_W-1:0]  exp;
    logic [LO_W-1:0]   shift_lo;
    logic              zero;
    logic              denorm;
  } norm_item_t;

endpackage

// File: rtl/norm_shift_stage.sv
// One valid/ready pipeline register that left-shifts the mantissa by in_amt * SHIFT_SCALE on load.
module norm_shift_stage
  import fp_pkg::*;
#(
  parameter int SHIFT_SCALE = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  norm_item_t       in_item,
  input  logic [LO_W-1:0]  in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output norm_item_t       out_item
);

  logic       valid_reg;
  norm_item_t item_reg;
  norm_item_t item_next;
  logic       advance;

  // Empty stage, or the occupant leaves this cycle: either way we can load.
  assign advance  = ~valid_reg | out_ready;
  assign in_ready = advance;

  always_comb begin
    item_next      = in_item;
    item_next.mant = in_item.mant << (32'(in_amt) * SHIFT_SCALE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_reg <= 1'b0;
      item_reg  <= '0;
    end else if (advance) begin
      valid_reg <= in_valid;
      if (in_valid) begin
        item_reg <= item_next;
      end
    end
  end

  assign out_valid = valid_reg;
  assign out_item  = item_reg;

endmodule

// File: rtl/mantissa_normalizer.sv
// Normalizes a post-add mantissa using the FFO leading-one index: coarse byte shift, then fine bit shift.
module mantissa_normalizer
  import fp_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] in_mant,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [IDX_W-1:0]  in_idx,
  input  logic              in_idx_valid,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] out_mant,
  output logic [EXP_W-1:0]  out_exp,
  output logic              out_zero,
  output logic              out_denorm
);

  logic [IDX_W-1:0] shift;
  logic [IDX_W-1:0] shift_eff;
  logic             shift_ge_exp;
  logic [LO_W-1:0]  a_amt;
  norm_item_t       a_in;
  norm_item_t       a_item;
  norm_item_t       b_item;
  logic             a_valid;
  logic             b_ready;
  logic             unused_shift_lo;

  always_comb begin
    shift = '0;
    if (in_idx < IDX_W'(MANT_W)) begin
      shift = IDX_W'(MANT_W - 1) - in_idx;
    end
    shift_ge_exp = {{(EXP_W - IDX_W){1'b0}}, shift} >= in_exp;
    // When clamping, in_exp <= shift <= MANT_W-1, so it fits the shift width.
    shift_eff = shift_ge_exp ? in_exp[IDX_W-1:0] : shift;

    a_in = '0;
    if (in_idx_valid) begin
      a_in.mant     = in_mant;
      a_in.exp      = in_exp - EXP_W'(shift_eff);
      a_in.shift_lo = shift_eff[2:0];
      a_in.denorm   = shift_ge_exp;
    end else begin
      a_in.zero = 1'b1;
    end
    a_amt = {1'b0, shift_eff[4:3]};
  end

  always_ff @(posedge clock) begin
    if (!reset && in_valid && in_idx_valid) begin
      assert (in_idx < IDX_W'(MANT_W));
    end
  end

  norm_shift_stage #(.SHIFT_SCALE(8)) stage_a (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_item   (a_in),
    .in_amt    (a_amt),
    .out_valid (a_valid),
    .out_ready (b_ready),
    .out_item  (a_item)
  );

  norm_shift_stage #(.SHIFT_SCALE(1)) stage_b (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (a_valid),
    .in_ready  (b_ready),
    .in_item   (a_item),
    .in_amt    (a_item.shift_lo),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_item  (b_item)
  );

  assign out_mant        = b_item.mant;
  assign out_exp         = b_item.exp;
  assign out_zero        = b_item.zero;
  assign out_denorm      = b_item.denorm;
  // The fine shift amount has been consumed by the time it reaches the output stage.
  assign unused_shift_lo = ^b_item.shift_lo;

endmodule
